spi_rx: RTL and testbench
=========================

SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 The block SHALL have no parameters; FIFO depth is fixed at 4 words and word width at 16 bits.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 spi_cs_l  input  1  active-low frame select from the SPI master.
REQ-005 spi_sclk  input  1  serial clock from the master, period >= 4 clk cycles.
REQ-006 spi_data  input  1  serial data, MSB first, stable around spi_sclk rising edge.
REQ-007 rd_en  input  1  pop request; SHALL be ignored when rd_valid=0.
REQ-008 rd_data  output  16  word at FIFO head; don't-care when rd_valid=0.
REQ-009 rd_valid  output  1  FIFO not empty.
REQ-010 fifo_count  output  3  words held, 0..4.
REQ-011 bit_cnt  output  5  bits received in current frame, 0..15.
REQ-012 frame_err  output  1  one-cycle pulse: frame aborted with partial word.
REQ-013 overflow  output  1  one-cycle pulse: completed word dropped because FIFO full.

Function
REQ-014 The block SHALL pass spi_cs_l, spi_sclk and spi_data through 2-flop synchronizers, plus one extra sclk flop for edge detection.
REQ-015 Sclk rise is detected when sync stage 2 = 1 and stage 3 = 0; the bit is sampled from synchronized spi_data stage 2 in that cycle.
REQ-016 Latency: the shift register SHALL update at the second clk edge after the first edge that samples spi_sclk high (E0 sample, E2 update).
REQ-017 State machine: IDLE, SHIFT.
REQ-018 IDLE -> SHIFT when synchronized cs_l = 0; bit_cnt is 0 in IDLE; sclk rises in IDLE SHALL be ignored.
REQ-019 In SHIFT, each sclk rise SHALL shift the bit into the LSB and increment bit_cnt.
REQ-020 On the 16th bit (bit_cnt=15 plus a rise), the word {shift[14:0], bit} SHALL be pushed into the FIFO at that same edge.
REQ-021 After the 16th bit, bit_cnt SHALL wrap to 0 and the block remains in SHIFT; back-to-back words within one cs_l-low window SHALL be supported.
REQ-022 SHIFT -> IDLE when synchronized cs_l = 1.
REQ-023 If cs_l rises with bit_cnt != 0, frame_err SHALL pulse for one cycle and the partial word SHALL be discarded.
REQ-024 If cs_l rises with bit_cnt = 0, there SHALL be no error.
REQ-025 If cs_l rise and an sclk rise are detected in the same cycle, cs_l SHALL take priority and the bit SHALL be discarded.
REQ-026 FIFO: 4-entry circular buffer with 2-bit read and write pointers that wrap 3 -> 0.
REQ-027 rd_data SHALL show the head entry combinationally from the read pointer.
REQ-028 Pop: rd_en=1 and rd_valid=1 advance the read pointer at the clock edge.
REQ-029 Push when fifo_count=4 and no pop in that cycle: the word SHALL be dropped, overflow SHALL pulse, and FIFO contents SHALL stay unchanged.
REQ-030 Simultaneous push and pop SHALL both be accepted at any count, including full; fifo_count stays unchanged.
REQ-031 fifo_count SHALL increment on push only, decrement on pop only, and never leave 0..4.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL go to state IDLE with:
- bit_cnt=0, shift register=0, pointers=0;
- fifo_count=0, rd_valid=0, frame_err=0, overflow=0;
- synchronizer flops: cs_l stages=1, sclk/data stages=0.
REQ-033 Reset mid-frame SHALL discard the partial word and stored words without pulsing frame_err.
REQ-034 After reset, the block SHALL wait for a new cs_l falling edge before receiving a word.

Verification
REQ-035 Single frame: cs_l low, 16'hA569 sent MSB first with sclk = clk/8 -> after the 16th rise, rd_valid=1, rd_data=16'hA569, fifo_count=1, frame_err=0.
REQ-036 Back-to-back: 16'h2563 then 16'h9B63 with cs_l held low; rd_en pulsed once after both -> 2563 popped first, rd_data=9B63, fifo_count=1.
REQ-037 Abort: 8 bits of 16'h6A61 then cs_l high -> frame_err pulses exactly once, fifo_count unchanged, bit_cnt=0.
REQ-038 Overflow: 5 words (A265, 7564, 0001, 0002, 0003) with no reads -> overflow pulses once on the 5th word; fifo_count=4; pops return A265, 7564, 0001, 0002.
REQ-039 Full with simultaneous pop: FIFO full, rd_en=1 in the cycle the 5th word completes -> no overflow, fifo_count stays 4, new word stored at the tail.
REQ-040 Reset mid-frame: rst=1 after 10 bits with 2 words stored -> all outputs return to reset values; the next full frame 16'hFFFF is received correctly.

Source files
------------

// File: rtl/spi_rx.sv
// SPI slave receiver: synchronises the master's cs_l/sclk/data into clk,
// assembles 16-bit MSB-first words and queues them in a 4-entry FIFO.
module spi_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_cs_l,
   input  logic        spi_sclk,
   input  logic        spi_data,
   input  logic        rd_en,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic [2:0]  fifo_count,
   output logic [4:0]  bit_cnt,
   output logic        frame_err,
   output logic        overflow,
   output logic        fsm_state
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state;
   logic        cs_s1, cs_s2;
   logic        sclk_s1, sclk_s2, sclk_s3;
   logic        data_s1, data_s2;
   logic [15:0] shift_reg;
   logic [15:0] mem [4];
   logic [1:0]  wr_ptr, rd_ptr;

   logic        sclk_rise;
   logic        push;
   logic        pop;
   logic        accept;
   logic [15:0] push_word;

   // Two-flop synchronisers; sclk has a third flop so a rising edge is seen
   // as stage 2 high with stage 3 still low.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         data_s1 <= 1'b0;
         data_s2 <= 1'b0;
      end else begin
         cs_s1   <= spi_cs_l;
         cs_s2   <= cs_s1;
         sclk_s1 <= spi_sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         data_s1 <= spi_data;
         data_s2 <= data_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   // cs_l deassertion wins over a coincident sclk rise, so no push then.
   assign push      = (state == SHIFT) & ~cs_s2 & sclk_rise & (bit_cnt == 5'd15);
   assign push_word = {shift_reg[14:0], data_s2};

   // Read handshake: rd_valid means rd_data holds the FIFO head; a word is
   // consumed on any clk edge where rd_en and rd_valid are both high.
   // rd_en while rd_valid is low has no effect.
   assign pop       = rd_en & rd_valid;
   assign accept    = push & ((fifo_count != 3'd4) | pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= 5'd0;
         shift_reg <= 16'd0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= 5'd0;
               if (!cs_s2) state <= SHIFT;
            end
            SHIFT: begin
               if (cs_s2) begin
                  state     <= IDLE;
                  bit_cnt   <= 5'd0;
                  shift_reg <= 16'd0;
                  if (bit_cnt != 5'd0) frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  shift_reg <= push_word;
                  bit_cnt   <= (bit_cnt == 5'd15) ? 5'd0 : bit_cnt + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
         overflow   <= 1'b0;
      end else begin
         overflow <= push & ~accept;
         if (accept) wr_ptr <= wr_ptr + 2'd1;
         if (pop)    rd_ptr <= rd_ptr + 2'd1;
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Storage needs no reset; contents are only meaningful while rd_valid.
   // When full with a pop, wr_ptr equals rd_ptr and the head is being
   // consumed in the same edge, so the overwrite is safe.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= push_word;
   end

   assign rd_data   = mem[rd_ptr];
   assign rd_valid  = (fifo_count != 3'd0);
   assign fsm_state = (state == SHIFT);

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: table of single-word frames plus hand-written sequences
// for back-to-back, abort, overflow, full-with-pop and mid-frame reset.
module tb_spi_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_cs_l;
   logic        spi_sclk;
   logic        spi_data;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [2:0]  fifo_count;
   logic [4:0]  bit_cnt;
   logic        frame_err;
   logic        overflow;
   logic        fsm_state;

   spi_rx dut (
      .clk        (clk),
      .rst        (rst),
      .spi_cs_l   (spi_cs_l),
      .spi_sclk   (spi_sclk),
      .spi_data   (spi_data),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .fifo_count (fifo_count),
      .bit_cnt    (bit_cnt),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .fsm_state  (fsm_state)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          fe_cnt = 0;
   int          ov_cnt = 0;
   int          exp_fe = 0;
   int          exp_ov = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [15:0] word;
      logic [2:0]  exp_count;
      bit          pop_after;
   } vec_t;

   vec_t tbl[6];

   // Pulse monitors count high cycles, so a stretched pulse also shows up.
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overflow === 1'b1)  ov_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_frame();
      spi_cs_l = 1'b0;
      spi_sclk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic end_frame();
      spi_sclk = 1'b0;
      spi_cs_l = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // sclk = clk/8: 4 cycles low then 4 high per bit; the push lands at the
   // third rising clk edge after sclk goes high.
   task automatic send_bits(input logic [15:0] w, input int nbits, input bit pop_last);
      logic [15:0] e;
      for (int i = 0; i < nbits; i++) begin
         spi_data = w[15-i];
         spi_sclk = 1'b0;
         repeat (4) @(negedge clk);
         spi_sclk = 1'b1;
         repeat (2) @(negedge clk);
         if (pop_last && i == nbits - 1) begin
            if (exp_q.size() == 0) begin
               check("pop_at_full_model_empty", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pop_at_full_data", {16'd0, rd_data}, {16'd0, e});
               rd_en = 1'b1;
            end
         end
         @(negedge clk);
         rd_en = 1'b0;
         @(negedge clk);
      end
      spi_sclk = 1'b0;
      if (nbits == 16) begin
         if (exp_q.size() < 4) exp_q.push_back(w);
         else exp_ov++;
      end
   endtask

   task automatic pop_check(input string name);
      logic [15:0] e;
      check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         check({name, "_model_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({name, "_data"}, {16'd0, rd_data}, {16'd0, e});
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      spi_cs_l = 1'b1;
      spi_sclk = 1'b0;
      spi_data = 1'b0;
      rd_en    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_count",    {29'd0, fifo_count}, 32'd0);
      check("rst_valid",    {31'd0, rd_valid},   32'd0);
      check("rst_bit_cnt",  {27'd0, bit_cnt},    32'd0);
      check("rst_frame_err",{31'd0, frame_err},  32'd0);
      check("rst_overflow", {31'd0, overflow},   32'd0);
      check("rst_state",    {31'd0, fsm_state},  32'd0);

      // rd_en on an empty FIFO must be ignored
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
      check("empty_pop_count", {29'd0, fifo_count}, 32'd0);

      tbl[0] = '{16'hA569, 3'd1, 1'b0};
      tbl[1] = '{16'h0000, 3'd2, 1'b0};
      tbl[2] = '{16'hFFFF, 3'd3, 1'b1};
      tbl[3] = '{16'h8001, 3'd3, 1'b0};
      tbl[4] = '{16'h7FFE, 3'd4, 1'b1};
      tbl[5] = '{16'($urandom_range(0, 65535)), 3'd4, 1'b0};

      for (int i = 0; i < 6; i++) begin
         start_frame();
         send_bits(tbl[i].word, 16, 1'b0);
         check("tbl_count",   {29'd0, fifo_count}, {29'd0, tbl[i].exp_count});
         check("tbl_bit_cnt", {27'd0, bit_cnt},    32'd0);
         check("tbl_head",    {16'd0, rd_data},    {16'd0, exp_q[0]});
         end_frame();
         check("tbl_no_err",  fe_cnt, exp_fe);
         if (tbl[i].pop_after) pop_check("tbl_pop");
      end
      while (exp_q.size() > 0) pop_check("tbl_drain");
      check("tbl_drained", {29'd0, fifo_count}, 32'd0);

      // back-to-back words in one cs_l window
      start_frame();
      send_bits(16'h2563, 16, 1'b0);
      send_bits(16'h9B63, 16, 1'b0);
      check("b2b_count", {29'd0, fifo_count}, 32'd2);
      end_frame();
      check("b2b_no_err", fe_cnt, exp_fe);
      pop_check("b2b_pop1");
      check("b2b_head2",  {16'd0, rd_data},    32'h9B63);
      check("b2b_count1", {29'd0, fifo_count}, 32'd1);
      pop_check("b2b_pop2");

      // abort after 8 bits
      start_frame();
      send_bits(16'h6A61, 8, 1'b0);
      check("abort_bit_cnt_mid", {27'd0, bit_cnt}, 32'd8);
      end_frame();
      exp_fe++;
      check("abort_frame_err", fe_cnt, exp_fe);
      check("abort_count",   {29'd0, fifo_count}, 32'd0);
      check("abort_bit_cnt", {27'd0, bit_cnt},    32'd0);
      check("abort_state",   {31'd0, fsm_state},  32'd0);

      // overflow on the fifth word
      start_frame();
      send_bits(16'hA265, 16, 1'b0);
      send_bits(16'h7564, 16, 1'b0);
      send_bits(16'h0001, 16, 1'b0);
      send_bits(16'h0002, 16, 1'b0);
      check("ovf_no_pulse_yet", ov_cnt, exp_ov);
      send_bits(16'h0003, 16, 1'b0);
      check("ovf_pulse", ov_cnt, exp_ov);
      check("ovf_count", {29'd0, fifo_count}, 32'd4);
      end_frame();
      while (exp_q.size() > 0) pop_check("ovf_drain");
      check("ovf_drained", {29'd0, fifo_count}, 32'd0);

      // full FIFO with a pop in the push cycle
      start_frame();
      send_bits(16'h1111, 16, 1'b0);
      send_bits(16'h2222, 16, 1'b0);
      send_bits(16'h3333, 16, 1'b0);
      send_bits(16'h4444, 16, 1'b0);
      check("fullpop_count_before", {29'd0, fifo_count}, 32'd4);
      send_bits(16'h5555, 16, 1'b1);
      check("fullpop_no_ovf", ov_cnt, exp_ov);
      check("fullpop_count",  {29'd0, fifo_count}, 32'd4);
      end_frame();
      while (exp_q.size() > 0) pop_check("fullpop_drain");

      // reset mid-frame with two words stored
      start_frame();
      send_bits(16'hABCD, 16, 1'b0);
      send_bits(16'h1357, 16, 1'b0);
      send_bits(16'hC0DE, 10, 1'b0);
      check("midrst_bit_cnt_pre", {27'd0, bit_cnt},    32'd10);
      check("midrst_count_pre",   {29'd0, fifo_count}, 32'd2);
      rst      = 1'b1;
      spi_cs_l = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_count",   {29'd0, fifo_count}, 32'd0);
      check("midrst_valid",   {31'd0, rd_valid},   32'd0);
      check("midrst_bit_cnt", {27'd0, bit_cnt},    32'd0);
      check("midrst_state",   {31'd0, fsm_state},  32'd0);
      repeat (4) @(negedge clk);
      check("midrst_no_err",  fe_cnt, exp_fe);
      check("midrst_no_ovf",  ov_cnt, exp_ov);
      start_frame();
      send_bits(16'hFFFF, 16, 1'b0);
      check("midrst_new_count", {29'd0, fifo_count}, 32'd1);
      check("midrst_new_head",  {16'd0, rd_data},    32'hFFFF);
      end_frame();
      pop_check("midrst_pop");
      check("final_frame_err", fe_cnt, exp_fe);
      check("final_overflow",  ov_cnt, exp_ov);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
